// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// Each stage resolves one SLICE-bit slice with a two-level (4-bit group)
// lookahead and hands its carry-out to the next stage. A single global
// enable stalls the whole pipe when the result is not being consumed.
module pipe_cla_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_ovf
);

   localparam int unsigned STAGES = WIDTH / SLICE;
   localparam int unsigned NGRP   = SLICE / 4;

   if ((WIDTH % SLICE) != 0 || (SLICE % 4) != 0) begin : g_cfg_err
      $error("pipe_cla_adder: WIDTH must be a multiple of SLICE and SLICE a multiple of 4");
   end

   // Two-level lookahead over one slice; returns {carry_out, sum}.
   // Group and bit carries are written as flat sum-of-products so no carry
   // ripples from one group into the next.
   function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b,
                                                input logic             cin);
      logic [SLICE-1:0] g, p, c;
      logic [NGRP-1:0]  gg, gp;
      logic [NGRP:0]    gc;
      logic             t;
      g = a & b;
      p = a | b;
      for (int unsigned j = 0; j < NGRP; j++) begin
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end
      gc    = '0;
      gc[0] = cin;
      for (int unsigned j = 0; j < NGRP; j++) begin
         t = cin;
         for (int unsigned m = 0; m <= j; m++) t = t & gp[m];
         gc[j+1] = t;
         for (int unsigned k = 0; k <= j; k++) begin
            t = gg[k];
            for (int unsigned m = k + 1; m <= j; m++) t = t & gp[m];
            gc[j+1] = gc[j+1] | t;
         end
      end
      c = '0;
      for (int unsigned j = 0; j < NGRP; j++) begin
         for (int unsigned bi = 0; bi < 4; bi++) begin
            t = gc[j];
            for (int unsigned m = 0; m < bi; m++) t = t & p[4*j+m];
            c[4*j+bi] = t;
            for (int unsigned k = 0; k < bi; k++) begin
               t = g[4*j+k];
               for (int unsigned m = k + 1; m < bi; m++) t = t & p[4*j+m];
               c[4*j+bi] = c[4*j+bi] | t;
            end
         end
      end
      return {gc[NGRP], (a ^ b) ^ c};
   endfunction

   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] carry_q, carry_d;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic              ovf_q, ovf_d;
   logic              enable;
   logic              unused_last_ops;

   logic              src_v, src_c;
   logic [WIDTH-1:0]  src_a, src_b, src_s;
   logic [SLICE:0]    res;

   // Final-stage operand copies exist only to keep every stage the same shape.
   assign unused_last_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

   // Next-state for every stage: resolve own slice from the upstream register.
   always_comb begin
      enable  = !valid_q[STAGES-1] | out_ready;
      valid_d = valid_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      src_v   = 1'b0;
      src_c   = 1'b0;
      src_a   = '0;
      src_b   = '0;
      src_s   = '0;
      res     = '0;
      if (enable) begin
         for (int unsigned i = 0; i < STAGES; i++) begin
            if (i == 0) begin
               src_v = in_valid;
               src_a = in_a;
               src_b = in_sub ? ~in_b : in_b;
               src_c = in_cin ^ in_sub;
               src_s = '0;
            end else begin
               src_v = valid_q[i-1];
               src_a = a_q[i-1];
               src_b = b_q[i-1];
               src_c = carry_q[i-1];
               src_s = sum_q[i-1];
            end
            res        = cla_slice(src_a[i*SLICE +: SLICE], src_b[i*SLICE +: SLICE], src_c);
            valid_d[i] = src_v;
            a_d[i]     = src_a;
            b_d[i]     = src_b;
            carry_d[i] = res[SLICE];
            sum_d[i]   = src_s;
            sum_d[i][i*SLICE +: SLICE] = res[SLICE-1:0];
            if (i == STAGES - 1) begin
               // carry into the MSB is recovered from the MSB sum bit
               ovf_d = res[SLICE] ^ (src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ res[SLICE-1]);
            end
         end
      end
   end

   // Pipeline registers; reset discards all in-flight beats at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         carry_q <= '0;
         ovf_q   <= 1'b0;
         for (int unsigned i = 0; i < STAGES; i++) begin
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            sum_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
      end
   end

   assign in_ready  = enable;
   assign out_valid = valid_q[STAGES-1];
   assign out_sum   = sum_q[STAGES-1];
   assign out_carry = carry_q[STAGES-1];
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder (WIDTH=32, SLICE=16).
module tb_pipe_cla_adder;

   localparam int unsigned W      = 32;
   localparam int unsigned S      = 16;
   localparam int unsigned STAGES = W / S;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         carry;
      logic         ovf;
   } res_t;

   logic         clk, rst;
   logic         in_valid, in_ready, in_cin, in_sub;
   logic [W-1:0] in_a, in_b, out_sum;
   logic         out_valid, out_ready, out_carry, out_ovf;

   int   n_cmp = 0;
   int   n_err = 0;
   res_t sb[$];

   logic cap_in_fire, cap_out_fire, cap_valid, cap_in_ready, cap_have;
   res_t cap_got, cap_exp;

   pipe_cla_adder #(.WIDTH(W), .SLICE(S)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Golden model: plain (W+1)-bit arithmetic.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      logic [W:0]   full, cv;
      logic [W-1:0] bb;
      res_t         r;
      bb    = sub ? ~b : b;
      cv    = '0;
      cv[0] = cin ^ sub;
      full  = {1'b0, a} + {1'b0, bb} + cv;
      r.sum   = full[W-1:0];
      r.carry = full[W];
      r.ovf   = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
      return r;
   endfunction

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom % 6)
         0:       v = '1;
         1:       v = '0;
         2:       v = {1'b0, {(W-1){1'b1}}};
         3:       v = {1'b1, {(W-1){1'b0}}};
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   // One clock cycle: drive, sample away from the edge, keep the scoreboard.
   task automatic tick(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input logic ordy);
      in_valid = v; in_a = a; in_b = b; in_cin = cin; in_sub = sub; out_ready = ordy;
      #1;
      cap_valid    = out_valid;
      cap_in_ready = in_ready;
      cap_got      = '{out_sum, out_carry, out_ovf};
      cap_in_fire  = v & in_ready;
      cap_out_fire = out_valid & ordy;
      cap_have     = 1'b0;
      cap_exp      = '0;
      if (cap_out_fire && sb.size() > 0) begin
         cap_exp  = sb.pop_front();
         cap_have = 1'b1;
      end
      if (cap_in_fire) sb.push_back(model(a, b, cin, sub));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
      #12;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      n_cmp++; if (out_sum !== '0) begin n_err++; $display("FAIL reset_sum got %h exp 0", out_sum); end
      n_cmp++; if (out_carry !== 1'b0) begin n_err++; $display("FAIL reset_carry got %b exp 0", out_carry); end
      n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", out_ovf); end
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_after got %b exp 0", out_valid); end
   endtask

   task automatic test_vector(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic sub, input logic [W-1:0] exp_sum,
                              input logic exp_c, input logic exp_ovf);
      int unsigned lat;
      bit          done;
      tick(1'b1, a, b, cin, sub, 1'b1);
      n_cmp++; if (cap_in_fire !== 1'b1) begin n_err++; $display("FAIL %s_accept got %b exp 1", name, cap_in_fire); end
      lat  = 0;
      done = 0;
      while (!done && lat < 20) begin
         tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         lat++;
         if (cap_out_fire) done = 1;
      end
      n_cmp++;
      if (!done) begin
         n_err++; $display("FAIL %s_timeout got no result exp result within 20 cycles", name);
      end else begin
         if (lat != STAGES) begin n_err++; $display("FAIL %s_latency got %0d exp %0d", name, lat, STAGES); end
         n_cmp++; if (cap_got.sum !== exp_sum) begin n_err++; $display("FAIL %s_sum got %h exp %h", name, cap_got.sum, exp_sum); end
         n_cmp++; if (cap_got.carry !== exp_c) begin n_err++; $display("FAIL %s_carry got %b exp %b", name, cap_got.carry, exp_c); end
         n_cmp++; if (cap_got.ovf !== exp_ovf) begin n_err++; $display("FAIL %s_ovf got %b exp %b", name, cap_got.ovf, exp_ovf); end
      end
   endtask

   task automatic test_back_to_back();
      int unsigned t, sent, got;
      logic        ordy;
      res_t        held;
      t = 0; sent = 0; got = 0; held = '0;
      while (got < 8 && t < 60) begin
         ordy = !(t >= STAGES + 1 && t <= STAGES + 3);
         tick(sent < 8, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), ordy);
         if (cap_in_fire) sent++;
         if (!ordy) begin
            n_cmp++; if (cap_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready t=%0d got %b exp 0", t, cap_in_ready); end
            n_cmp++; if (cap_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid t=%0d got %b exp 1", t, cap_valid); end
            if (t > STAGES + 1) begin
               n_cmp++; if (cap_got !== held) begin n_err++; $display("FAIL stall_hold t=%0d got %h exp %h", t, cap_got, held); end
            end
            held = cap_got;
         end
         if (cap_out_fire) begin
            got++;
            n_cmp++;
            if (!cap_have) begin n_err++; $display("FAIL b2b_extra got result %h exp none", cap_got); end
            else if (cap_got !== cap_exp) begin n_err++; $display("FAIL b2b_data got %h exp %h", cap_got, cap_exp); end
         end
         t++;
      end
      n_cmp++; if (got != 8) begin n_err++; $display("FAIL b2b_count got %0d exp 8", got); end
      n_cmp++; if (t != 8 + STAGES + 3) begin n_err++; $display("FAIL b2b_cycles got %0d exp %0d", t, 8 + STAGES + 3); end
   endtask

   task automatic test_reset_midflight();
      int unsigned lat;
      bit          done;
      tick(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0);
      tick(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b1, 1'b0);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid got %b exp 1", out_valid); end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid got %b exp 0", out_valid); end
      n_cmp++; if (out_sum !== '0) begin n_err++; $display("FAIL mid_async_sum got %h exp 0", out_sum); end
      #2;
      rst = 1'b0;
      sb.delete();
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         n_cmp++; if (cap_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale cycle=%0d got %b exp 0", i, cap_valid); end
      end
      tick(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      lat = 0; done = 0;
      while (!done && lat < 20) begin
         tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         lat++;
         if (cap_out_fire) done = 1;
      end
      n_cmp++;
      if (!done) begin n_err++; $display("FAIL mid_next_timeout got no result exp result"); end
      else if (lat != STAGES) begin n_err++; $display("FAIL mid_next_latency got %0d exp %0d", lat, STAGES); end
      n_cmp++; if (cap_got !== cap_exp) begin n_err++; $display("FAIL mid_next_data got %h exp %h", cap_got, cap_exp); end
   endtask

   task automatic test_random();
      int unsigned sent, t, bad;
      logic        v, ordy;
      sent = 0; t = 0; bad = 0;
      while ((sent < 3000 || sb.size() > 0) && t < 20000) begin
         v    = (sent < 3000) && ($urandom % 4 != 0);
         ordy = ($urandom % 10) < 7;
         tick(v, pick(), pick(), 1'($urandom), 1'($urandom), ordy);
         if (cap_in_fire) sent++;
         n_cmp++;
         if (cap_in_ready !== (!cap_valid | ordy)) begin
            n_err++; bad++;
            if (bad < 10) $display("FAIL rnd_in_ready t=%0d got %b exp %b", t, cap_in_ready, !cap_valid | ordy);
         end
         if (cap_out_fire) begin
            n_cmp++;
            if (!cap_have) begin
               n_err++; bad++;
               if (bad < 10) $display("FAIL rnd_extra t=%0d got %h exp none", t, cap_got);
            end else if (cap_got !== cap_exp) begin
               n_err++; bad++;
               if (bad < 10) $display("FAIL rnd_data t=%0d got %h exp %h", t, cap_got, cap_exp);
            end
         end
         t++;
      end
      n_cmp++; if (sb.size() != 0 || sent != 3000) begin n_err++; $display("FAIL rnd_drain got sent=%0d pending=%0d exp sent=3000 pending=0", sent, sb.size()); end
   endtask

   initial begin
      test_reset();
      test_vector("carry_cross", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      test_vector("pos_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      test_vector("sub_neg",     32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      test_vector("sub_borrow",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_cla_adder.md
# pipe_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the fixed 16-bit single-cycle adder. It splits a WIDTH-bit operation into SLICE-bit lookahead slices, with one register stage per slice, and forwards the carry between stages. It sits between an operand source and a result consumer, with valid/ready handshakes on both sides. It sustains one operation per cycle and reports carry and signed overflow.

## Interface
Parameters:
- WIDTH, 32: operand width. Must be a multiple of SLICE.
- SLICE, 16: bits resolved per pipeline stage. Must be a multiple of 4.
- Derived: STAGES = WIDTH/SLICE, which is also the latency in cycles.

Ports:
- clk, in, 1: the single clock; all state updates on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: operand beat is present.
- in_ready, out, 1: block can accept a beat this cycle.
- in_a, in, WIDTH: operand A.
- in_b, in, WIDTH: operand B.
- in_cin, in, 1: carry-in (borrow-in when subtracting).
- in_sub, in, 1: 0 selects A+B; 1 selects A−B.
- out_valid, out, 1: result beat is present.
- out_ready, in, 1: consumer accepts the result.
- out_sum, out, WIDTH: result.
- out_carry, out, 1: carry out of the MSB.
- out_ovf, out, 1: two's-complement signed overflow.

## Operation
- Operand preparation:
  - Effective B is `in_sub ? ~in_b : in_b`.
  - Bit-0 carry is `in_cin ^ in_sub`.
  - Therefore sub with cin=0 gives A−B, and sub with cin=1 gives A−B−1.
- Per-bit signals: g = a & b_eff, p = a | b_eff, sum bit = (a ^ b_eff) ^ carry.
- Each SLICE is a two-level lookahead:
  - 4-bit groups produce group G/P.
  - A group-level lookahead yields the group carries and the slice carry-out.
  - No ripple between groups.
- Stage i (0..STAGES−1):
  - Resolves slice i using the carry registered by stage i−1 (stage 0 uses the bit-0 carry).
  - Registers its slice sum and carry-out.
  - Passes the not-yet-consumed upper operand slices forward.
  - Already-resolved lower sum slices are delayed so the full result emerges aligned.
- Flags, taken from the final slice:
  - out_carry = carry out of bit WIDTH−1. In subtract mode, 1 means no borrow.
  - out_ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Flow control is a global stall:
  - enable = !out_valid | out_ready.
  - in_ready = enable.
  - Every stage register, including the per-stage valid bits, advances only when enable=1.
  - When enable=1, stage 0 loads valid = in_valid.
- Bubbles are not squeezed out. A bubble occupies a stage exactly like data.
- While out_valid=1 and out_ready=0:
  - out_sum, out_carry and out_ovf are held stable.
  - No beat is lost or duplicated.
  - in_ready=0.
- Configuration checks: WIDTH not a multiple of SLICE, or SLICE not a multiple of 4, is a configuration error flagged by an elaboration-time check.

## Timing
- Reset (asynchronous, active-high):
  - All valid bits clear, so out_valid=0.
  - out_sum=0, out_carry=0, out_ovf=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Input transfer occurs on a rising edge where in_valid & in_ready = 1.
- Latency: a beat transferred at edge k appears on the outputs after edge k+STAGES−1, provided no stall intervenes. Each stall cycle adds one cycle.
- Throughput: one beat per cycle when out_ready is held at 1.
- With STAGES=1 the block reduces to a registered adder with latency 1.
- Output transfer occurs on an edge where out_valid & out_ready = 1. A new beat, or a bubble with out_valid=0, replaces it on the same edge.
- Reset asserted mid-operation:
  - All in-flight beats are discarded immediately (asynchronous).
  - out_valid drops without waiting for a clock.
  - Beats are never partially emitted after reset.
- Combinational path: one SLICE lookahead per stage. Critical path is independent of WIDTH.

## Test plan
- WIDTH=32, SLICE=16:
  - Stimulus: A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0.
  - Response: after 2 cycles, sum=0x00000000, carry=1, ovf=0.
  - This exercises carry crossing the stage boundary.
- Stimulus: A=0x7FFFFFFF, B=0x00000001, add.
  - Response: sum=0x80000000, carry=0, ovf=1.
- Stimulus: A=5, B=7, sub=1, cin=0.
  - Response: sum=0xFFFFFFFE, carry=0, ovf=0.
- Stimulus: A=7, B=5, sub=1, cin=1.
  - Response: sum=0x00000001, carry=1.
- Backpressure:
  - Stimulus: stream 8 consecutive beats; drop out_ready for 3 cycles in the middle.
  - Response: in_ready=0 during the stall; outputs held stable; all 8 results arrive in order with no gaps beyond the stall.
- Reset mid-flight:
  - Stimulus: assert rst while 2 beats are in flight.
  - Response: out_valid=0 immediately; no stale result after release; the next beat completes with correct latency.
- Random regression:
  - Stimulus: 10k random add/sub/cin beats with random out_ready, at (WIDTH,SLICE) = (16,16), (32,16), (64,16) and (64,8).
  - Response: every result matches a (WIDTH+1)-bit golden model, including carry and ovf.
